adc_frame_controller: RTL and testbench

ADC_FRAME_CONTROLLER -- requirements
Module: adc_frame_controller

---
 rtl/adc_pkg.sv | 25 ++
 rtl/adc_iir_channel.sv | 47 ++++
 rtl/adc_frame_controller.sv | 145 ++++++++++++++
 tb/tb_adc_frame_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types, widths and helpers for the ADC frame controller slice.
package adc_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned ADC_MAX_DEFAULT = 4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_FILTER,
    ST_PRESENT
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] ch0;
    logic [DATA_W-1:0] ch1;
  } frame_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/adc_iir_channel.sv
// One smoothing channel: first sample after priming loads directly, later
// samples move the output a 2^-SMOOTH_SHIFT fraction toward the new value.
module adc_iir_channel
  import adc_pkg::*;
#(
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned ADC_MAX      = ADC_MAX_DEFAULT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] value_o
);

  localparam logic signed [DATA_W:0] MAX_S = (DATA_W+1)'(ADC_MAX);

  logic [DATA_W-1:0]        value_q, value_d;
  logic signed [DATA_W:0]   diff_c, step_c, sum_c;

  always_comb begin
    diff_c  = $signed({1'b0, sample_i}) - $signed({1'b0, value_q});
    step_c  = diff_c >>> SMOOTH_SHIFT;
    sum_c   = $signed({1'b0, value_q}) + step_c;
    value_d = value_q;
    if (en_i) begin
      if (load_i) begin
        value_d = sample_i;
      end else if (sum_c[DATA_W]) begin
        value_d = '0;
      end else if (sum_c > MAX_S) begin
        value_d = DATA_W'(ADC_MAX);
      end else begin
        value_d = sum_c[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/adc_frame_controller.sv
// Synchronizes SPI frame-complete, settles/captures two ADC samples, rejects
// out-of-range frames, smooths and presents them, and watches link health.
module adc_frame_controller
  import adc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned SMOOTH_SHIFT   = 2,
  parameter int unsigned ADC_MAX        = ADC_MAX_DEFAULT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_data_received,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_pitch,
  output logic [DATA_W-1:0] o_harmonics,
  output logic              o_link_ok,
  output logic [CNT_W-1:0]  o_error_count,
  output logic [CNT_W-1:0]  o_overrun_count
);

  localparam int unsigned       WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_W-1:0] MAX_W    = DATA_W'(ADC_MAX);

  // [0],[1] synchronizer stages, [2] previous synchronized level
  logic [2:0]       sync_q;
  logic             frame_evt_c;
  logic [WD_W-1:0]  wd_q;
  logic             timeout_c;

  state_e           state_q;
  logic             settle_q;
  frame_t           hold_q;
  logic             valid_q;
  logic             link_q;
  logic             primed_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] ovr_q;
  logic             filt_en_c;

  assign frame_evt_c = sync_q[1] & ~sync_q[2];
  assign timeout_c   = (wd_q == WD_LIMIT);
  assign filt_en_c   = (state_q == ST_FILTER);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], i_data_received};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          wd_q <= '0;
    else if (frame_evt_c) wd_q <= '0;
    else if (!timeout_c)  wd_q <= wd_q + WD_W'(1);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      settle_q <= 1'b0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      link_q   <= 1'b0;
      primed_q <= 1'b0;
      err_q    <= '0;
      ovr_q    <= '0;
    end else begin
      // Lost link forgets the filter history so the next good frame loads directly
      if (timeout_c) begin
        link_q   <= 1'b0;
        primed_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_evt_c) begin
            state_q  <= ST_SETTLE;
            settle_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_q) begin
            hold_q  <= '{ch0: i_data0, ch1: i_data1};
            state_q <= ST_CHECK;
          end else begin
            settle_q <= 1'b1;
          end
        end
        ST_CHECK: begin
          if ((hold_q.ch0 > MAX_W) || (hold_q.ch1 > MAX_W)) begin
            err_q   <= sat_inc(err_q);
            state_q <= ST_IDLE;
          end else begin
            link_q  <= 1'b1;
            state_q <= ST_FILTER;
          end
        end
        ST_FILTER: begin
          primed_q <= 1'b1;
          valid_q  <= 1'b1;
          state_q  <= ST_PRESENT;
        end
        ST_PRESENT: begin
          // An accepted frame is not an overrun even if a new one lands the same cycle
          if (i_ready) begin
            valid_q  <= 1'b0;
            settle_q <= 1'b0;
            state_q  <= frame_evt_c ? ST_SETTLE : ST_IDLE;
          end else if (frame_evt_c) begin
            ovr_q    <= sat_inc(ovr_q);
            valid_q  <= 1'b0;
            settle_q <= 1'b0;
            state_q  <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  adc_iir_channel #(.SMOOTH_SHIFT(SMOOTH_SHIFT), .ADC_MAX(ADC_MAX)) u_pitch (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .en_i     (filt_en_c),
    .load_i   (~primed_q),
    .sample_i (hold_q.ch0),
    .value_o  (o_pitch)
  );

  adc_iir_channel #(.SMOOTH_SHIFT(SMOOTH_SHIFT), .ADC_MAX(ADC_MAX)) u_harm (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .en_i     (filt_en_c),
    .load_i   (~primed_q),
    .sample_i (hold_q.ch1),
    .value_o  (o_harmonics)
  );

  assign o_valid         = valid_q;
  assign o_link_ok       = link_q;
  assign o_error_count   = err_q;
  assign o_overrun_count = ovr_q;

endmodule

// File: tb/tb_adc_frame_controller.sv
// Scenario bench for adc_frame_controller with a queue-based scoreboard.
module tb_adc_frame_controller;

  localparam int unsigned TO    = 64;
  localparam int unsigned SHIFT = 2;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_data_received = 1'b0;
  logic [15:0] i_data0 = '0;
  logic [15:0] i_data1 = '0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [15:0] o_pitch;
  logic [15:0] o_harmonics;
  logic        o_link_ok;
  logic [7:0]  o_error_count;
  logic [7:0]  o_overrun_count;

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_p = 0;
  int   m_h = 0;
  bit   m_primed = 0;

  adc_frame_controller #(.TIMEOUT_CYCLES(TO), .SMOOTH_SHIFT(SHIFT), .ADC_MAX(4095)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_data_received (i_data_received),
    .i_data0         (i_data0),
    .i_data1         (i_data1),
    .i_ready         (i_ready),
    .o_valid         (o_valid),
    .o_pitch         (o_pitch),
    .o_harmonics     (o_harmonics),
    .o_link_ok       (o_link_ok),
    .o_error_count   (o_error_count),
    .o_overrun_count (o_overrun_count)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  function automatic int smooth(input int out, input int cap);
    int d;
    d = cap - out;
    return out + (d >>> SHIFT);
  endfunction

  // Expected value of a frame that passes range checking
  task automatic model_good(input int d0, input int d1);
    exp_t e;
    if (!m_primed) begin
      m_p = d0;
      m_h = d1;
      m_primed = 1;
    end else begin
      m_p = smooth(m_p, d0);
      m_h = smooth(m_h, d1);
    end
    e.p = m_p;
    e.h = m_h;
    sb.push_back(e);
  endtask

  task automatic drive_frame(input logic [15:0] d0, input logic [15:0] d1);
    @(negedge i_clock);
    i_data0 = d0;
    i_data1 = d1;
    i_data_received = 1'b1;
  endtask

  task automatic release_frame();
    @(negedge i_clock);
    i_data_received = 1'b0;
    repeat (3) @(negedge i_clock);
  endtask

  task automatic wait_valid(input int max, output int cyc, output bit seen);
    cyc = 0;
    seen = 0;
    while (cyc < max && !seen) begin
      @(negedge i_clock);
      cyc++;
      if (o_valid) seen = 1;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b0 || o_link_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags valid=%b link=%b required 0 0", o_valid, o_link_ok);
    end
    checks++;
    if (o_pitch !== 16'd0 || o_harmonics !== 16'd0) begin
      errors++;
      $display("FAIL reset_data pitch=%0d harm=%0d required 0 0", o_pitch, o_harmonics);
    end
    checks++;
    if (o_error_count !== 8'd0 || o_overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts err=%0d ovr=%0d required 0 0", o_error_count, o_overrun_count);
    end
    i_reset = 1'b0;
    repeat (2) @(negedge i_clock);
  endtask

  task automatic test_first_frame();
    int cyc; bit seen; exp_t e;
    i_ready = 1'b1;
    drive_frame(16'd1000, 16'd2000);
    model_good(1000, 2000);
    wait_valid(20, cyc, seen);
    checks++;
    if (!seen || cyc != 7) begin
      errors++;
      $display("FAIL first_latency seen=%0d cycles=%0d required 1 7", seen, cyc);
    end
    e = sb.pop_front();
    checks++;
    if (o_pitch !== 16'(e.p) || o_harmonics !== 16'(e.h)) begin
      errors++;
      $display("FAIL first_data pitch=%0d harm=%0d required %0d %0d", o_pitch, o_harmonics, e.p, e.h);
    end
    checks++;
    if (o_link_ok !== 1'b1) begin
      errors++;
      $display("FAIL first_link link=%b required 1", o_link_ok);
    end
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_handshake_drop valid=%b required 0", o_valid);
    end
    release_frame();
  endtask

  task automatic test_smoothing();
    int cyc; bit seen; exp_t e;
    int want[2] = '{1250, 1437};
    for (int k = 0; k < 2; k++) begin
      drive_frame(16'd2000, 16'd2000);
      model_good(2000, 2000);
      wait_valid(20, cyc, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || o_pitch !== 16'(e.p) || o_harmonics !== 16'(e.h)) begin
        errors++;
        $display("FAIL smooth_%0d seen=%0d pitch=%0d harm=%0d required %0d %0d",
                 k, seen, o_pitch, o_harmonics, e.p, e.h);
      end
      checks++;
      if (o_pitch !== 16'(want[k])) begin
        errors++;
        $display("FAIL smooth_abs_%0d pitch=%0d required %0d", k, o_pitch, want[k]);
      end
      release_frame();
    end
  endtask

  task automatic test_error();
    int cyc; bit seen;
    drive_frame(16'd5000, 16'd100);
    wait_valid(15, cyc, seen);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL err_no_valid valid seen after %0d cycles required none", cyc);
    end
    checks++;
    if (o_error_count !== 8'd1) begin
      errors++;
      $display("FAIL err_count err=%0d required 1", o_error_count);
    end
    checks++;
    if (o_pitch !== 16'(m_p) || o_harmonics !== 16'(m_h)) begin
      errors++;
      $display("FAIL err_hold pitch=%0d harm=%0d required %0d %0d", o_pitch, o_harmonics, m_p, m_h);
    end
    release_frame();
  endtask

  task automatic test_overrun();
    int cyc; bit seen; exp_t e; logic [15:0] held;
    i_ready = 1'b0;
    drive_frame(16'd3000, 16'd500);
    model_good(3000, 500);
    wait_valid(20, cyc, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || o_pitch !== 16'(e.p) || o_harmonics !== 16'(e.h)) begin
      errors++;
      $display("FAIL ovr_first seen=%0d pitch=%0d harm=%0d required %0d %0d",
               seen, o_pitch, o_harmonics, e.p, e.h);
    end
    held = o_pitch;
    release_frame();
    checks++;
    if (o_valid !== 1'b1 || o_pitch !== held) begin
      errors++;
      $display("FAIL ovr_stable valid=%b pitch=%0d required 1 %0d", o_valid, o_pitch, held);
    end
    drive_frame(16'd1500, 16'd800);
    model_good(1500, 800);
    cyc = 0;
    while (cyc < 10 && o_valid) begin
      @(negedge i_clock);
      cyc++;
    end
    checks++;
    if (o_valid !== 1'b0 || o_overrun_count !== 8'd1) begin
      errors++;
      $display("FAIL ovr_count valid=%b ovr=%0d required 0 1", o_valid, o_overrun_count);
    end
    wait_valid(20, cyc, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || o_pitch !== 16'(e.p) || o_harmonics !== 16'(e.h)) begin
      errors++;
      $display("FAIL ovr_second seen=%0d pitch=%0d harm=%0d required %0d %0d",
               seen, o_pitch, o_harmonics, e.p, e.h);
    end
    i_ready = 1'b1;
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b0 || o_overrun_count !== 8'd1) begin
      errors++;
      $display("FAIL ovr_accept valid=%b ovr=%0d required 0 1", o_valid, o_overrun_count);
    end
    release_frame();
  endtask

  task automatic test_timeout();
    int cyc; bit seen; exp_t e;
    repeat (TO + 6) @(negedge i_clock);
    checks++;
    if (o_link_ok !== 1'b0) begin
      errors++;
      $display("FAIL timeout_link link=%b required 0", o_link_ok);
    end
    m_primed = 0;
    drive_frame(16'd3000, 16'd3000);
    model_good(3000, 3000);
    wait_valid(20, cyc, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || o_pitch !== 16'(e.p) || o_pitch !== 16'd3000) begin
      errors++;
      $display("FAIL timeout_reload seen=%0d pitch=%0d required 3000", seen, o_pitch);
    end
    checks++;
    if (o_link_ok !== 1'b1) begin
      errors++;
      $display("FAIL timeout_relink link=%b required 1", o_link_ok);
    end
    release_frame();
  endtask

  task automatic test_reset_mid_frame();
    int cyc; bit seen; exp_t e;
    drive_frame(16'd2500, 16'd2500);
    repeat (3) @(negedge i_clock);
    i_reset = 1'b1;
    i_data_received = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b0 || o_pitch !== 16'd0 || o_harmonics !== 16'd0 || o_link_ok !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outs valid=%b pitch=%0d harm=%0d link=%b required 0 0 0 0",
               o_valid, o_pitch, o_harmonics, o_link_ok);
    end
    checks++;
    if (o_error_count !== 8'd0 || o_overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL midreset_counts err=%0d ovr=%0d required 0 0", o_error_count, o_overrun_count);
    end
    i_reset = 1'b0;
    repeat (4) @(negedge i_clock);
    m_primed = 0;
    sb.delete();
    drive_frame(16'd2500, 16'd1200);
    model_good(2500, 1200);
    wait_valid(20, cyc, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || o_pitch !== 16'(e.p) || o_harmonics !== 16'(e.h)) begin
      errors++;
      $display("FAIL midreset_first seen=%0d pitch=%0d harm=%0d required %0d %0d",
               seen, o_pitch, o_harmonics, e.p, e.h);
    end
    checks++;
    if (o_link_ok !== 1'b1 || o_error_count !== 8'd0 || o_overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL midreset_status link=%b err=%0d ovr=%0d required 1 0 0",
               o_link_ok, o_error_count, o_overrun_count);
    end
    release_frame();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_smoothing();
    test_error();
    test_overrun();
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
